mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Single-owner controller for the byte-wide unified RAM port. It arbitrates between the I-cache word-fetch requester and the load/store buffer, and serialises each 1/2/4-byte access into byte transfers. Reads are assembled little-endian into 32-bit results; writes are split into bytes. It sits between the I-cache/LSB and the top-level RAM/IO pins.

Parameters:
IO_MASK, 32'h0003_0000, address bits that mark an IO access when all are set.

Ports:
clk  in  1  system clock.
rst  in  1  reset, asynchronous, active-low.
rdy  in  1  global enable; low freezes the block.
clear  in  1  ROB flush pulse; aborts an in-flight read.
ic_req  in  1  I-cache fetch request, held until ic_done.
ic_addr  in  32  fetch address; always a word access.
ic_done  out  1  one-cycle pulse; ic_data valid.
ic_data  out  32  fetched word.
ls_req  in  1  LSB request, held until ls_done.
ls_we  in  1  1 = store, 0 = load.
ls_addr  in  32  byte address.
ls_size  in  2  0 = byte, 1 = half, 2 = word.
ls_wdata  in  32  store data; low bytes used.
ls_done  out  1  one-cycle pulse.
ls_rdata  out  32  load data, zero-extended; the LSB sign-extends.
mem_din  in  8  RAM read byte; reflects mem_a of the previous cycle.
mem_dout  out  8  RAM write byte.
mem_a  out  32  RAM byte address.
mem_wr  out  1  1 = write this cycle.
io_buffer_full  in  1  IO write sink cannot accept.

Behaviour:
- Reset (rst low, async): state = IDLE, cnt = 0, last_grant = IC; every output is 0.
- States: IDLE, READ, WRITE. N is the byte count: 4 for IC, else 1 << ls_size.
- IDLE, arbitration:
  - Only one requester active: grant it.
  - Both active: grant the one not equal to last_grant, so LSB wins the first tie after reset.
  - A requester is ignored in IDLE during the cycle its done is high.
  - On grant: latch base, N, we and wdata; set cnt = 0 and last_grant; go to READ or WRITE.
- Cycle numbering: edge E0 accepts the request. Cycle k is the cycle after edge E_k.
- READ:
  - In cycle k < N: mem_a = base + k, mem_wr = 0.
  - At edge E_{k+1} for k ≥ 1: capture mem_din into byte k-1 of the result.
  - At edge E_{N+1}: the requester's done goes high for exactly one cycle with data; state returns to IDLE.
  - Word read: done in cycle 5. Byte read: done in cycle 2.
  - Cycle N drives mem_a = 0.
- WRITE:
  - Cycle k < N: mem_wr = 1, mem_a = base + k, mem_dout = wdata[8k+7:8k].
  - IO access (base & IO_MASK == IO_MASK) with io_buffer_full high: mem_wr = 0 and cnt holds; resume when it falls.
  - After the last byte is issued, ls_done pulses on the next edge, then IDLE.
  - Normal word store: ls_done in cycle 4.
- Outside active transfer cycles: mem_wr = 0, mem_a = 0, mem_dout = 0.
- clear:
  - In READ (either requester): return to IDLE next edge; no done, partial data discarded; last_grant keeps its updated value.
  - In WRITE: ignored; stores are committed and always complete.
  - In IDLE: also blocks acceptance that cycle.
- rdy low:
  - All registers hold and mem_wr = 0.
  - In READ, mem_a re-presents base + cnt - 1 (0 when cnt = 0) so mem_din stays valid for the pending capture.
  - No capture happens during the stall. On rdy high, the sequence continues unchanged.
- Address arithmetic is 32-bit wraparound; alignment is not checked.
- done outputs are registered; ic_data and ls_rdata hold their last value until the next done.

Decomposition:
- Shared package: state encodings (IDLE/READ/WRITE), size codes (SZ_B/SZ_H/SZ_W), grant ids (G_IC/G_LS), IO_MASK default.
- Sub-module rr_arb2: 2-way round-robin grant from (ic_req, ls_req, last_grant, blocked); combinational plus last_grant register.
- Byte sequencing stays in mem_arbiter.

Test Plan:
- Fetch: RAM[0x100..0x103] = 13 05 00 00; ic_req with ic_addr = 0x100 → mem_a 0x100..0x103 in cycles 0-3; ic_done in cycle 5 with ic_data = 0x00000513; mem_wr stays 0.
- Tie: ic_req and ls_req (load word 0x200) raised together after reset → LSB served first (ls_done), then IC. The next simultaneous tie grants IC.
- Store to IO: ls_we = 1, ls_addr = 0x30000, size byte, wdata = 0x41, io_buffer_full high for 3 cycles → mem_wr held 0 for 3 cycles, then one write of 0x41 to 0x30000; ls_done one cycle later.
- Half load: ls_addr = 0x10, RAM = 0xFE 0xFF → ls_rdata = 0x0000FFFE in cycle 3.
- clear pulsed in cycle 2 of a word fetch → no ic_done; IDLE next cycle; a subsequent ls_req is served normally.
- rdy low for 4 cycles in cycle 2 of a word read → result identical to the unstalled run; ic_done delayed by exactly 4 cycles; mem_wr never 1.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified byte-wide RAM port controller.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  typedef enum logic {
    G_IC = 1'b0,
    G_LS = 1'b1
  } grant_t;

  // Address bits that, when all set, mark a memory-mapped IO access.
  localparam logic [31:0] IO_MASK_DEFAULT = 32'h0003_0000;

  // Byte count of an LSB access; the unused size code is treated as a word.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size_t'(size))
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-pin bundle of the memory arbiter.
// master: the arbiter itself; slave: I-cache, LSB and RAM/IO pins.
interface mem_arbiter_if;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_done;
  logic [31:0] ic_data;

  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [1:0]  ls_size;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;

  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport master (
    input  ic_req, ic_addr, ls_req, ls_we, ls_addr, ls_size, ls_wdata,
           mem_din, io_buffer_full,
    output ic_done, ic_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );

  modport slave (
    output ic_req, ic_addr, ls_req, ls_we, ls_addr, ls_size, ls_wdata,
           mem_din, io_buffer_full,
    input  ic_done, ic_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant between I-cache and LSB. A tie goes to the
// requester that did not win last time; last_grant updates on acceptance.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   ic_req,
  input  logic   ls_req,
  input  logic   block_ic,
  input  logic   block_ls,
  input  logic   accept,
  output logic   grant_valid,
  output grant_t grant
);

  grant_t last_grant;
  logic   ic_ok;
  logic   ls_ok;

  // Grant selection from the live (unblocked) requests.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    grant       = G_IC;
    ic_ok       = ic_req & ~block_ic;
    ls_ok       = ls_req & ~block_ls;
    grant_valid = ic_ok | ls_ok;
    if (ic_ok && ls_ok) begin
      grant = (last_grant == G_IC) ? G_LS : G_IC;
    end else if (ls_ok) begin
      grant = G_LS;
    end
  end

  // Remember the winner of each accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      last_grant <= G_IC;
    end else if (accept) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-owner controller for the byte-wide RAM port: arbitrates I-cache and
// LSB, serialises 1/2/4-byte accesses, assembles reads little-endian.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [31:0] IO_MASK = IO_MASK_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          clear,
  mem_arbiter_if.master bus
);

  state_t      state;
  state_t      state_next;
  grant_t      owner;
  grant_t      grant;
  logic        grant_valid;
  logic [2:0]  cnt;
  logic [2:0]  nbytes;
  logic [31:0] base;
  logic [31:0] wdata;
  logic [31:0] rbuf;
  logic [31:0] rd_word;
  logic [1:0]  cap_idx;
  logic        ic_done_q;
  logic        ls_done_q;
  logic [31:0] ic_data_q;
  logic [31:0] ls_rdata_q;

  logic        accept;
  logic        rd_step;
  logic        rd_capture;
  logic        rd_last;
  logic        wr_issue;
  logic        io_stall;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;

  // A requester is held off during its own done cycle, since its req is
  // still high for that cycle.
  rr_arb2 u_arb (
    .clk         (clk),
    .rst_n       (rst),
    .ic_req      (bus.ic_req),
    .ls_req      (bus.ls_req),
    .block_ic    (ic_done_q),
    .block_ls    (ls_done_q),
    .accept      (accept),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // State register; rdy low freezes the sequence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else if (rdy) begin
      state <= state_next;
    end
  end

  // Next state, byte sequencing and RAM pin drive.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    rd_step    = 1'b0;
    rd_capture = 1'b0;
    rd_last    = 1'b0;
    wr_issue   = 1'b0;
    mem_a      = 32'd0;
    mem_wr     = 1'b0;
    mem_dout   = 8'd0;
    io_stall   = ((base & IO_MASK) == IO_MASK) && bus.io_buffer_full;
    // mem_din holds the byte addressed one cycle earlier, i.e. byte cnt-1.
    cap_idx    = cnt[1:0] - 2'd1;
    rd_word    = rbuf;
    rd_word[{cap_idx, 3'b000} +: 8] = bus.mem_din;

    case (state)
      ST_IDLE: begin
        if (rdy && !clear && grant_valid) begin
          accept     = 1'b1;
          state_next = (grant == G_LS && bus.ls_we) ? ST_WRITE : ST_READ;
        end
      end
      ST_READ: begin
        if (!rdy) begin
          // Re-present the previous address so the pending byte stays valid.
          if (cnt != 3'd0) mem_a = base + 32'(cnt) - 32'd1;
        end else begin
          if (cnt < nbytes) mem_a = base + 32'(cnt);
          if (clear) begin
            state_next = ST_IDLE;
          end else begin
            rd_step    = (cnt < nbytes);
            rd_capture = (cnt != 3'd0);
            if (cnt == nbytes) begin
              rd_last    = 1'b1;
              state_next = ST_IDLE;
            end
          end
        end
      end
      ST_WRITE: begin
        if (rdy && !io_stall) begin
          wr_issue = 1'b1;
          mem_wr   = 1'b1;
          mem_a    = base + 32'(cnt);
          mem_dout = wdata[{cnt[1:0], 3'b000} +: 8];
          if (cnt == nbytes - 3'd1) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request latch, byte counter, read assembly and registered done/data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner      <= G_IC;
      cnt        <= 3'd0;
      nbytes     <= 3'd0;
      base       <= 32'd0;
      wdata      <= 32'd0;
      rbuf       <= 32'd0;
      ic_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      ic_data_q  <= 32'd0;
      ls_rdata_q <= 32'd0;
    end else if (rdy) begin
      ic_done_q <= 1'b0;
      ls_done_q <= 1'b0;
      if (accept) begin
        owner <= grant;
        cnt   <= 3'd0;
        // Cleared so narrow loads come out zero-extended.
        rbuf  <= 32'd0;
        wdata <= bus.ls_wdata;
        if (grant == G_IC) begin
          base   <= bus.ic_addr;
          nbytes <= 3'd4;
        end else begin
          base   <= bus.ls_addr;
          nbytes <= size_to_bytes(bus.ls_size);
        end
      end
      if (rd_step || wr_issue) cnt <= cnt + 3'd1;
      if (rd_capture) rbuf <= rd_word;
      if (rd_last) begin
        if (owner == G_IC) begin
          ic_data_q <= rd_word;
          ic_done_q <= 1'b1;
        end else begin
          ls_rdata_q <= rd_word;
          ls_done_q  <= 1'b1;
        end
      end
      if (wr_issue && cnt == nbytes - 3'd1) ls_done_q <= 1'b1;
    end
  end

  assign bus.ic_done  = ic_done_q;
  assign bus.ic_data  = ic_data_q;
  assign bus.ls_done  = ls_done_q;
  assign bus.ls_rdata = ls_rdata_q;
  assign bus.mem_a    = mem_a;
  assign bus.mem_wr   = mem_wr;
  assign bus.mem_dout = mem_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected dones
// and RAM writes; negedge monitors pop and compare.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rdy   = 1'b1;
  logic clear = 1'b0;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_ls;
    bit          chk_data;
    logic [31:0] data;
    int          cyc;
  } done_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  done_t done_q[$];
  wr_t   wr_q[$];
  done_t de;
  wr_t   we_item;

  logic [7:0] ram [bit [31:0]];

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event, expected none (cycle %0d)", name, cyc);
  endtask

  task automatic exp_done(input bit is_ls, input bit chk, input logic [31:0] data, input int c);
    done_t e;
    e.is_ls = is_ls; e.chk_data = chk; e.data = data; e.cyc = c;
    done_q.push_back(e);
  endtask

  task automatic exp_wr(input logic [31:0] addr, input logic [7:0] data, input int c);
    wr_t w;
    w.addr = addr; w.data = data; w.cyc = c;
    wr_q.push_back(w);
  endtask

  // RAM model: mem_din reflects the previous cycle's mem_a.
  always @(posedge clk) begin
    if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
    bus.mem_din <= ram_rd(bus.mem_a);
  end

  // Done monitor.
  always @(negedge clk) begin
    if (rst && (bus.ic_done || bus.ls_done)) begin
      if (bus.ic_done && bus.ls_done) fail("both_done");
      if (done_q.size() == 0) begin
        fail("unexpected_done");
      end else begin
        de = done_q.pop_front();
        check("done_owner", {31'd0, bus.ls_done}, {31'd0, de.is_ls});
        if (de.chk_data) check(de.is_ls ? "ls_rdata" : "ic_data",
                               de.is_ls ? bus.ls_rdata : bus.ic_data, de.data);
        if (de.cyc >= 0) check("done_cycle", 32'(cyc), 32'(de.cyc));
      end
    end
  end

  // RAM write monitor.
  always @(negedge clk) begin
    if (rst && bus.mem_wr) begin
      if (wr_q.size() == 0) begin
        fail("unexpected_write");
      end else begin
        we_item = wr_q.pop_front();
        check("wr_addr", bus.mem_a, we_item.addr);
        check("wr_data", {24'd0, bus.mem_dout}, {24'd0, we_item.data});
        check("wr_cycle", 32'(cyc), 32'(we_item.cyc));
      end
    end
  end

  task automatic ic_drive(input logic [31:0] addr);
    bus.ic_addr = addr;
    bus.ic_req  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.ic_done) begin
        bus.ic_req = 1'b0;
        return;
      end
    end
    fail("ic_timeout");
    bus.ic_req = 1'b0;
  endtask

  task automatic ls_drive(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wdata);
    bus.ls_we    = we;
    bus.ls_addr  = addr;
    bus.ls_size  = size;
    bus.ls_wdata = wdata;
    bus.ls_req   = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.ls_done) begin
        bus.ls_req = 1'b0;
        return;
      end
    end
    fail("ls_timeout");
    bus.ls_req = 1'b0;
  endtask

  int c;

  initial begin
    bus.ic_req = 0; bus.ic_addr = 0;
    bus.ls_req = 0; bus.ls_we = 0; bus.ls_addr = 0; bus.ls_size = 0; bus.ls_wdata = 0;
    bus.io_buffer_full = 0;
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
    ram[32'h104] = 8'hef; ram[32'h105] = 8'hbe; ram[32'h106] = 8'had; ram[32'h107] = 8'hde;
    ram[32'h200] = 8'h11; ram[32'h201] = 8'h22; ram[32'h202] = 8'h33; ram[32'h203] = 8'h44;
    ram[32'h010] = 8'hfe; ram[32'h011] = 8'hff;

    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ic_done", {31'd0, bus.ic_done}, 32'd0);
    check("rst_ls_done", {31'd0, bus.ls_done}, 32'd0);
    check("rst_ic_data", bus.ic_data, 32'd0);
    check("rst_ls_rdata", bus.ls_rdata, 32'd0);
    check("rst_mem_a", bus.mem_a, 32'd0);
    check("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    check("rst_mem_dout", {24'd0, bus.mem_dout}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Word fetch: addresses in cycles 0-3, idle address in cycle 4, done in 5.
    c = cyc;
    exp_done(0, 1, 32'h0000_0513, c + 6);
    fork
      ic_drive(32'h100);
      begin
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("fetch_addr", bus.mem_a, 32'h100 + 32'(k));
        end
        @(negedge clk);
        check("fetch_addr_after", bus.mem_a, 32'd0);
      end
    join
    @(negedge clk);

    // First tie after reset: LSB first, then IC.
    exp_done(1, 1, 32'h4433_2211, -1);
    exp_done(0, 1, 32'hdead_beef, -1);
    fork
      ic_drive(32'h104);
      ls_drive(1'b0, 32'h200, SZ_W, 32'd0);
    join
    @(negedge clk);

    // LSB alone (byte load, done in cycle 2), leaving last_grant = LSB.
    c = cyc;
    exp_done(1, 1, 32'h0000_0044, c + 3);
    ls_drive(1'b0, 32'h203, SZ_B, 32'd0);
    @(negedge clk);

    // Tie with last_grant = LSB: IC wins.
    exp_done(0, 1, 32'h0000_0513, -1);
    exp_done(1, 1, 32'h0000_0011, -1);
    fork
      ic_drive(32'h100);
      ls_drive(1'b0, 32'h200, SZ_B, 32'd0);
    join
    @(negedge clk);

    // Normal word store: bytes in cycles 0-3, done in cycle 4.
    c = cyc;
    exp_wr(32'h300, 8'hd4, c + 1);
    exp_wr(32'h301, 8'hc3, c + 2);
    exp_wr(32'h302, 8'hb2, c + 3);
    exp_wr(32'h303, 8'ha1, c + 4);
    exp_done(1, 0, 32'd0, c + 5);
    ls_drive(1'b1, 32'h300, SZ_W, 32'ha1b2_c3d4);
    @(negedge clk);

    // IO byte store held off for 3 cycles by io_buffer_full.
    bus.io_buffer_full = 1'b1;
    c = cyc;
    exp_wr(32'h0003_0000, 8'h41, c + 4);
    exp_done(1, 0, 32'd0, c + 5);
    fork
      ls_drive(1'b1, 32'h0003_0000, SZ_B, 32'h41);
      begin
        repeat (4) @(posedge clk);
        #1 bus.io_buffer_full = 1'b0;
      end
    join
    @(negedge clk);

    // Non-IO store ignores io_buffer_full.
    bus.io_buffer_full = 1'b1;
    c = cyc;
    exp_wr(32'h304, 8'h5a, c + 1);
    exp_done(1, 0, 32'd0, c + 2);
    ls_drive(1'b1, 32'h304, SZ_B, 32'h5a);
    bus.io_buffer_full = 1'b0;
    @(negedge clk);

    // Read back the stored word.
    c = cyc;
    exp_done(1, 1, 32'ha1b2_c3d4, c + 6);
    ls_drive(1'b0, 32'h300, SZ_W, 32'd0);
    @(negedge clk);

    // Half load, zero-extended, done in cycle 3.
    c = cyc;
    exp_done(1, 1, 32'h0000_fffe, c + 4);
    ls_drive(1'b0, 32'h10, SZ_H, 32'd0);
    @(negedge clk);

    // clear in cycle 2 of a fetch: no done, idle in cycle 3.
    bus.ic_addr = 32'h100;
    bus.ic_req  = 1'b1;
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    check("clear_idle_addr", bus.mem_a, 32'd0);
    clear = 1'b0;
    bus.ic_req = 1'b0;
    @(negedge clk);
    c = cyc;
    exp_done(1, 1, 32'h4433_2211, c + 6);
    ls_drive(1'b0, 32'h200, SZ_W, 32'd0);
    @(negedge clk);

    // rdy low for 4 cycles from cycle 2 of a fetch: done moves from 5 to 9.
    c = cyc;
    exp_done(0, 1, 32'hdead_beef, c + 10);
    fork
      ic_drive(32'h104);
      begin
        repeat (3) @(posedge clk);
        #1 rdy = 1'b0;
        @(negedge clk);
        check("stall_addr", bus.mem_a, 32'h105);
        repeat (4) @(posedge clk);
        #1 rdy = 1'b1;
      end
    join

    repeat (5) @(negedge clk);
    check("done_queue_drained", 32'(done_q.size()), 32'd0);
    check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
